// File: rtl/synt_lock_seq_if.sv
// rtl/synt_lock_seq_if.sv - control/status bundle between power-control logic and the synth lock sequencer
interface synt_lock_seq_if #(
   parameter int N_CH  = 4,
   parameter int CNT_W = 7
);
   logic [N_CH-1:0]  PU_SYNT;
   logic [N_CH-1:0]  CAL_SYNT;
   logic [CNT_W-1:0] SETTLE_CNT;
   logic             ERR_CLR;
   logic [N_CH-1:0]  RDY_SYNT;
   logic [N_CH-1:0]  CAL_ERR;
   logic             RDY_ALL;

   modport master (
      output PU_SYNT, CAL_SYNT, SETTLE_CNT, ERR_CLR,
      input  RDY_SYNT, CAL_ERR, RDY_ALL
   );

   modport slave (
      input  PU_SYNT, CAL_SYNT, SETTLE_CNT, ERR_CLR,
      output RDY_SYNT, CAL_ERR, RDY_ALL
   );
endinterface

// File: rtl/synt_lock_seq.sv
// rtl/synt_lock_seq.sv - multi-channel synthesizer power-up / calibration lock sequencer
// Optional macro SYNT_RELOCK_EN: calibration in READY restarts a full settle.
module synt_lock_seq #(
   parameter int N_CH       = 4,
   parameter int CNT_W      = 7,
   parameter int SETTLE_DEF = 20,
   parameter int CAL_TMO    = 100
) (
   input logic              CLK,
   input logic              RST_N,
   synt_lock_seq_if.slave   syn_io
);

   localparam int TMR_W = (CAL_TMO > 0) ? $clog2(CAL_TMO + 1) : 1;
   localparam logic [TMR_W-1:0] TMR_MAX = '1;

   typedef enum logic [1:0] {S_OFF, S_SETTLE, S_READY, S_ERR} state_e;

   state_e            state_q [N_CH];
   state_e            state_d [N_CH];
   logic [CNT_W-1:0]  cnt_q   [N_CH];
   logic [CNT_W-1:0]  cnt_d   [N_CH];
   logic [TMR_W-1:0]  tmr_q   [N_CH];
   logic [TMR_W-1:0]  tmr_d   [N_CH];
   logic [N_CH-1:0]   rdy_q, rdy_d;
   logic [N_CH-1:0]   err_q, err_d;
   logic [CNT_W-1:0]  load_val;

   assign load_val = (syn_io.SETTLE_CNT == '0) ? CNT_W'(SETTLE_DEF) : syn_io.SETTLE_CNT;

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         for (int i = 0; i < N_CH; i++) begin
            state_q[i] <= S_OFF;
            cnt_q[i]   <= '0;
            tmr_q[i]   <= '0;
         end
         rdy_q <= '0;
         err_q <= '0;
      end else begin
         for (int i = 0; i < N_CH; i++) begin
            state_q[i] <= state_d[i];
            cnt_q[i]   <= cnt_d[i];
            tmr_q[i]   <= tmr_d[i];
         end
         rdy_q <= rdy_d;
         err_q <= err_d;
      end
   end

   always_comb begin
      rdy_d = '0;
      err_d = err_q;
      for (int i = 0; i < N_CH; i++) begin
         state_d[i] = state_q[i];
         cnt_d[i]   = cnt_q[i];
         tmr_d[i]   = tmr_q[i];
         if (!syn_io.PU_SYNT[i]) begin
            state_d[i] = S_OFF;
         end else begin
            case (state_q[i])
               S_OFF: begin
                  state_d[i] = S_SETTLE;
                  cnt_d[i]   = load_val;
                  tmr_d[i]   = '0;
               end
               S_SETTLE: begin
                  if (syn_io.CAL_SYNT[i]) begin
                     // tmr_q counts earlier consecutive CAL cycles, so this is the CAL_TMO-th one
                     if (tmr_q[i] != TMR_MAX) tmr_d[i] = tmr_q[i] + 1'b1;
                     if (CAL_TMO != 0 && int'(tmr_q[i]) == CAL_TMO - 1) state_d[i] = S_ERR;
                  end else begin
                     tmr_d[i] = '0;
                     if (cnt_q[i] != '0) cnt_d[i] = cnt_q[i] - 1'b1;
                     else                state_d[i] = S_READY;
                  end
               end
               S_READY: begin
`ifdef SYNT_RELOCK_EN
                  if (syn_io.CAL_SYNT[i]) begin
                     state_d[i] = S_SETTLE;
                     cnt_d[i]   = load_val;
                     tmr_d[i]   = '0;
                  end
`else
                  state_d[i] = S_READY;
`endif
               end
               default: state_d[i] = S_ERR;
            endcase
         end
         rdy_d[i] = (state_d[i] == S_READY);
         // entering or staying in ERR beats a same-edge clear
         if (state_d[i] == S_ERR)                            err_d[i] = 1'b1;
         else if (syn_io.ERR_CLR && state_q[i] != S_ERR)     err_d[i] = 1'b0;
      end
   end

   always_comb begin
      syn_io.RDY_SYNT = rdy_q;
      syn_io.CAL_ERR  = err_q;
      syn_io.RDY_ALL  = &rdy_q;
   end

endmodule

// File: tb/tb_synt_lock_seq.sv
// tb/tb_synt_lock_seq.sv - scoreboard bench for synt_lock_seq against a cycle-level behavioural model
module tb_synt_lock_seq;

   localparam int N_CH       = 4;
   localparam int CNT_W      = 7;
   localparam int SETTLE_DEF = 20;
   localparam int CAL_TMO    = 100;

   localparam int MD_OFF = 0, MD_SETTLE = 1, MD_READY = 2, MD_ERR = 3;

   typedef struct packed {
      logic [N_CH-1:0] rdy;
      logic [N_CH-1:0] err;
      logic            all;
   } exp_t;

   logic CLK = 1'b0;
   logic RST_N = 1'b0;

   synt_lock_seq_if #(.N_CH(N_CH), .CNT_W(CNT_W)) sif ();

   synt_lock_seq #(
      .N_CH(N_CH), .CNT_W(CNT_W), .SETTLE_DEF(SETTLE_DEF), .CAL_TMO(CAL_TMO)
   ) dut (
      .CLK(CLK),
      .RST_N(RST_N),
      .syn_io(sif)
   );

   always #5 CLK = ~CLK;

   exp_t exp_q[$];
   int   n_cmp = 0;
   int   n_fail = 0;
   int   n_cyc = 0;

   // model: rem = edges still needed before ready, run = consecutive CAL edges seen in settle
   int   m_mode [N_CH];
   int   m_rem  [N_CH];
   int   m_run  [N_CH];
   bit   m_err  [N_CH];

   task automatic model_edge(input logic rstn, input logic [N_CH-1:0] pu, input logic [N_CH-1:0] cal,
                             input logic [CNT_W-1:0] sc, input logic clr);
      exp_t e;
      int   prev;
      int   len;
      len = (sc == 0) ? SETTLE_DEF : int'(sc);
      for (int i = 0; i < N_CH; i++) begin
         prev = m_mode[i];
         if (!rstn) begin
            m_mode[i] = MD_OFF; m_rem[i] = 0; m_run[i] = 0; m_err[i] = 1'b0;
            continue;
         end
         if (!pu[i]) m_mode[i] = MD_OFF;
         else if (prev == MD_OFF) begin
            m_mode[i] = MD_SETTLE; m_rem[i] = len + 1; m_run[i] = 0;
         end else if (prev == MD_SETTLE) begin
            if (cal[i]) begin
               m_run[i]++;
               if (CAL_TMO != 0 && m_run[i] == CAL_TMO) m_mode[i] = MD_ERR;
            end else begin
               m_run[i] = 0;
               m_rem[i]--;
               if (m_rem[i] == 0) m_mode[i] = MD_READY;
            end
         end else if (prev == MD_READY) begin
`ifdef SYNT_RELOCK_EN
            if (cal[i]) begin
               m_mode[i] = MD_SETTLE; m_rem[i] = len + 1; m_run[i] = 0;
            end
`endif
         end
         if (m_mode[i] == MD_ERR)         m_err[i] = 1'b1;
         else if (clr && prev != MD_ERR)  m_err[i] = 1'b0;
      end
      for (int i = 0; i < N_CH; i++) begin
         e.rdy[i] = (m_mode[i] == MD_READY);
         e.err[i] = m_err[i];
      end
      e.all = &e.rdy;
      exp_q.push_back(e);
   endtask

   task automatic step(input logic rstn, input logic [N_CH-1:0] pu, input logic [N_CH-1:0] cal,
                       input logic [CNT_W-1:0] sc, input logic clr);
      @(negedge CLK);
      #2;
      RST_N          = rstn;
      sif.PU_SYNT    = pu;
      sif.CAL_SYNT   = cal;
      sif.SETTLE_CNT = sc;
      sif.ERR_CLR    = clr;
      model_edge(rstn, pu, cal, sc, clr);
   endtask

   always @(negedge CLK) begin
      exp_t e;
      n_cyc++;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         n_cmp++;
         if (sif.RDY_SYNT !== e.rdy) begin
            n_fail++;
            $display("FAIL rdy_synt cyc=%0d got=%b exp=%b", n_cyc, sif.RDY_SYNT, e.rdy);
         end
         n_cmp++;
         if (sif.CAL_ERR !== e.err) begin
            n_fail++;
            $display("FAIL cal_err cyc=%0d got=%b exp=%b", n_cyc, sif.CAL_ERR, e.err);
         end
         n_cmp++;
         if (sif.RDY_ALL !== e.all) begin
            n_fail++;
            $display("FAIL rdy_all cyc=%0d got=%b exp=%b", n_cyc, sif.RDY_ALL, e.all);
         end
      end
   end

   initial begin
      logic [N_CH-1:0] pu;
      logic [N_CH-1:0] cal;
      sif.PU_SYNT = '0; sif.CAL_SYNT = '0; sif.SETTLE_CNT = '0; sif.ERR_CLR = 1'b0;
      for (int i = 0; i < N_CH; i++) begin
         m_mode[i] = MD_OFF; m_rem[i] = 0; m_run[i] = 0; m_err[i] = 1'b0;
      end

      // reset held with all channels requesting power-up
      step(1'b0, 4'hF, 4'h0, 7'd0, 1'b0);
      step(1'b0, 4'hF, 4'h0, 7'd0, 1'b0);
      step(1'b1, 4'h0, 4'h0, 7'd0, 1'b0);

      // default settle length, then programmed length 5
      repeat (25) step(1'b1, 4'h1, 4'h0, 7'd0, 1'b0);
      repeat (2)  step(1'b1, 4'h0, 4'h0, 7'd5, 1'b0);
      repeat (10) step(1'b1, 4'h1, 4'h0, 7'd5, 1'b0);

      // CAL freeze on channel 1 mid-settle
      repeat (3)  step(1'b1, 4'h2, 4'h0, 7'd10, 1'b0);
      repeat (8)  step(1'b1, 4'h2, 4'h2, 7'd10, 1'b0);
      repeat (12) step(1'b1, 4'h2, 4'h0, 7'd10, 1'b0);

      // CAL timeout on channel 2, clear ignored in ERR, honoured after power-down
      step(1'b1, 4'h4, 4'h0, 7'd30, 1'b0);
      repeat (104) step(1'b1, 4'h4, 4'h4, 7'd30, 1'b0);
      step(1'b1, 4'h4, 4'h4, 7'd30, 1'b1);
      step(1'b1, 4'h0, 4'h0, 7'd30, 1'b0);
      step(1'b1, 4'h0, 4'h0, 7'd30, 1'b1);
      step(1'b1, 4'h0, 4'h0, 7'd30, 1'b0);

      // channel 3 aborted near the end of settle, then all channels lock together
      repeat (8)  step(1'b1, 4'h8, 4'h0, 7'd10, 1'b0);
      step(1'b1, 4'h0, 4'h0, 7'd10, 1'b0);
      repeat (10) step(1'b1, 4'hF, 4'h0, 7'd3, 1'b0);

      // single-cycle CAL on a locked channel
      step(1'b1, 4'hF, 4'h1, 7'd4, 1'b0);
      repeat (8)  step(1'b1, 4'hF, 4'h0, 7'd4, 1'b0);

      // randomized traffic
      pu = 4'hF;
      for (int k = 0; k < 700; k++) begin
         for (int i = 0; i < N_CH; i++) begin
            if (pu[i]) pu[i] = ($urandom_range(0, 39) != 0);
            else       pu[i] = ($urandom_range(0, 3) == 0);
            cal[i] = ($urandom_range(0, 5) == 0);
         end
         step(($urandom_range(0, 199) != 0), pu, cal, 7'($urandom_range(0, 12)),
              ($urandom_range(0, 9) == 0));
      end

      // long CAL with random clears to hit set-wins-over-clear
      step(1'b1, 4'h0, 4'h0, 7'd2, 1'b0);
      step(1'b1, 4'hF, 4'h0, 7'd2, 1'b0);
      for (int k = 0; k < 110; k++)
         step(1'b1, 4'hF, 4'hF, 7'd2, ($urandom_range(0, 2) == 0));
      step(1'b1, 4'hF, 4'h0, 7'd2, 1'b1);

      @(negedge CLK);
      @(negedge CLK);
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL drain got=%0d exp=0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
